nibble_serial_adder_display: RTL and testbench

- Parametrised successor of the team's 4-bit parallel adder with seven-segment output.
- Adds or subtracts two WIDTH-bit operands nibble-serially, reusing one 4-bit adder slice over DIGITS cycles.
- Holds the completed result in a register.
- Drives a time-multiplexed, active-low, DIGITS-wide seven-segment display showing that result in hex.
- Sits between board switches/controller logic and the display pins.

---
 rtl/nibble_serial_adder_display_pkg.sv | 54 +++++
 rtl/nibble_serial_adder_display_seg_mux_driver.sv | 73 +++++++
 rtl/nibble_serial_adder_display.sv | 147 ++++++++++++++
 tb/tb_nibble_serial_adder_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_display_pkg.sv
// Shared definitions for nibble_serial_adder_display: segment patterns,
// FSM state encoding and the hex-to-seven-segment lookup.
package nibble_serial_adder_display_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_A;
            4'hB:    pattern = SEG_B;
            4'hC:    pattern = SEG_C;
            4'hD:    pattern = SEG_D;
            4'hE:    pattern = SEG_E;
            4'hF:    pattern = SEG_F;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_display_seg_mux_driver.sv
// Time-multiplexed active-low seven-segment scanner for a DIGITS-nibble value.
// Optional leading-zero blanking is enabled by defining NIBBLE_ADDER_LZ_BLANK_EN.
module seg_mux_driver
    import nibble_serial_adder_display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     anode_o
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]     DIG_LAST = DW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       digit_q, digit_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic [4*DIGITS-1:0] shifted_s;
    logic                blank_s;

    // Refresh counter and digit index; anode/seg are derived from the next
    // digit so that both registers change on the same edge as the index.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        digit_d = digit_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CW{1'b0}};
            if (digit_q == DIG_LAST) begin
                digit_d = {DW{1'b0}};
            end else begin
                digit_d = digit_q + DW'(1);
            end
        end else begin
            digit_d = digit_q;
        end

        shifted_s = value_i >> {digit_d, 2'b00};
`ifdef NIBBLE_ADDER_LZ_BLANK_EN
        blank_s = (digit_d != {DW{1'b0}}) && (shifted_s == {(4*DIGITS){1'b0}});
`else
        blank_s = 1'b0;
`endif
        seg_d   = blank_s ? SEG_BLANK : hex_to_seg(shifted_s[3:0]);
        anode_d = ~(ONE_HOT0 << digit_d);
    end

    // Scan state and display output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {CW{1'b0}};
            digit_q <= {DW{1'b0}};
            anode_q <= ~ONE_HOT0;
            seg_q   <= SEG_0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_o   = seg_q;
    assign anode_o = anode_q;

endmodule

// File: rtl/nibble_serial_adder_display.sv
// Nibble-serial WIDTH-bit add/subtract unit with registered result and a
// multiplexed hex display. Build option: NIBBLE_ADDER_LZ_BLANK_EN (blanking).
module nibble_serial_adder_display
    import nibble_serial_adder_display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH-1:0]   sum,
    output logic               carry,
    output logic               overflow,
    output logic [6:0]         seg,
    output logic [WIDTH/4-1:0] anode
);

    localparam int DIGITS = WIDTH / 4;
    localparam int IDX_W  = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] IDX_FIN = IDX_W'(DIGITS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
    logic             c_q, c_d, cmsb_q, cmsb_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, busy_q, busy_d, valid_q, valid_d;
    logic [4:0]       slice_s;
    logic             accept_s;

    assign slice_s  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
    assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));

    // FSM next state and nibble datapath. Operands shift right one nibble per
    // ADD cycle; results enter the work register from the top, so after
    // DIGITS cycles nibble 0 sits at the bottom. idx == DIGITS is the
    // completion cycle that publishes the result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cmsb_d  = cmsb_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d = ADD;
                    idx_d   = {IDX_W{1'b0}};
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : cin;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ADD: begin
                if (idx_q == IDX_FIN) begin
                    state_d = DONE;
                    idx_d   = {IDX_W{1'b0}};
                    sum_d   = work_q;
                    carry_d = c_q;
                    ovf_d   = cmsb_q ^ c_q;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    a_d    = a_q >> 3'd4;
                    b_d    = b_q >> 3'd4;
                    c_d    = slice_s[4];
                    // Carry into bit 3 of this slice; the last nibble's value is the MSB carry-in.
                    cmsb_d = a_q[3] ^ b_q[3] ^ slice_s[3];
                    work_d = work_q >> 3'd4;
                    work_d[WIDTH-1 -: 4] = slice_s[3:0];
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cmsb_q  <= 1'b0;
            work_q  <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cmsb_q  <= cmsb_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

    seg_mux_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_seg_mux_driver (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_i (sum_q),
        .seg_o   (seg),
        .anode_o (anode)
    );

endmodule

// File: tb/tb_nibble_serial_adder_display.sv
// Self-checking bench for nibble_serial_adder_display at WIDTH=8, REFRESH_DIV=4.
module tb_nibble_serial_adder_display;

    localparam int W  = 8;
    localparam int RD = 4;
    localparam int DG = W / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, valid, carry, overflow;
    logic [W-1:0]  sum;
    logic [6:0]    seg;
    logic [DG-1:0] anode;

    int npass  = 0;
    int ntotal = 0;
    logic [6:0] hexpat [16];

    nibble_serial_adder_display #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .valid(valid), .sum(sum),
        .carry(carry), .overflow(overflow), .seg(seg), .anode(anode)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: integer arithmetic; overflow means the signed result leaves [-128,127].
    function automatic void model(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                                  input logic icin, output logic [7:0] s, output logic c,
                                  output logic v);
        int unsigned eb, tot;
        int sa, sb, sres;
        eb   = isub ? (32'(~ib) & 32'hFF) : 32'(ib);
        tot  = 32'(ia) + eb + (isub ? 32'd1 : 32'(icin));
        s    = tot[7:0];
        c    = (tot >= 32'd256);
        sa   = int'($signed(ia));
        sb   = int'($signed(ib));
        sres = isub ? (sa - sb) : (sa + sb + int'(icin));
        v    = (sres > 127) || (sres < -128);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [7:0] val, input int d);
        logic [7:0] sh;
        sh = val >> (4 * d);
`ifdef NIBBLE_ADDER_LZ_BLANK_EN
        if (d > 0 && sh == 8'h00) return 7'b1111111;
`endif
        return hexpat[sh[3:0]];
    endfunction

    logic [7:0] last_sum = 8'h00;

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                          input logic icin, output logic [7:0] s, output logic c,
                          output logic v);
        int lat;
        @(negedge clk);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("valid_low_after_start", {31'd0, valid}, 32'd0);
        lat = 0;
        while (!valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (!valid) check("sum_held_during_add", {24'd0, sum}, {24'd0, last_sum});
        end
        check("latency", lat, DG + 1);
        s = sum; c = carry; v = overflow;
        last_sum = sum;
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       sub, cin;
        logic [7:0] s;
        logic       c, v;
    } vec_t;
    vec_t vecs [8];

    initial begin
        logic [7:0] s, es;
        logic c, v, ec, ev;
        int n;
        logic [DG-1:0] cur;

        hexpat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs[0] = '{8'h3C, 8'h45, 1'b0, 1'b1, 8'h82, 1'b0, 1'b1};
        vecs[1] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h50, 8'h50, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_anode", {30'd0, anode}, 32'h2);
        check("rst_seg", {25'd0, seg}, 32'h40);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {31'd0, valid}, 32'd0);
        check("post_rst_carry", {31'd0, carry}, 32'd0);
        check("post_rst_ovf", {31'd0, overflow}, 32'd0);

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, s, c, v);
            check("vec_sum", {24'd0, s}, {24'd0, vecs[i].s});
            check("vec_carry", {31'd0, c}, {31'd0, vecs[i].c});
            check("vec_ovf", {31'd0, v}, {31'd0, vecs[i].v});
        end

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic rs, rc;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rc, es, ec, ev);
            run_op(ra, rb, rs, rc, s, c, v);
            check("rnd_sum", {24'd0, s}, {24'd0, es});
            check("rnd_carry", {31'd0, c}, {31'd0, ec});
            check("rnd_ovf", {31'd0, v}, {31'd0, ev});
        end

        // start while busy is ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valid && n < 10) begin @(negedge clk); n++; end
        check("busy_ignore_sum", {24'd0, sum}, 32'h46);
        check("busy_ignore_carry", {31'd0, carry}, 32'd0);
        check("busy_ignore_ovf", {31'd0, overflow}, 32'd0);
        check("busy_ignore_no_restart", {31'd0, busy}, 32'd0);

        // Reset during ADD abandons the operation
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_sum", {24'd0, sum}, 32'd0);
        check("midrst_carry", {31'd0, carry}, 32'd0);
        check("midrst_anode", {30'd0, anode}, 32'h2);
        check("midrst_seg", {25'd0, seg}, 32'h40);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (valid) n++;
        end
        check("midrst_valid_never", n, 0);
        check("midrst_sum_after", {24'd0, sum}, 32'd0);
        last_sum = 8'h00;

        // Display scan of 0xA5
        run_op(8'hA0, 8'h05, 1'b0, 1'b0, s, c, v);
        check("scan_sum", {24'd0, s}, 32'hA5);
        cur = anode;
        n = 0;
        while (anode == cur && n < 12) begin @(negedge clk); n++; end
        check("scan_first_change", {31'd0, (n < 12)}, 32'd1);
        for (int p = 0; p < 4; p++) begin
            cur = anode;
            check("scan_anode_onehot0", {31'd0, (cur == 2'b10 || cur == 2'b01)}, 32'd1);
            check("scan_seg", {25'd0, seg}, {25'd0, exp_seg(8'hA5, (cur == 2'b01) ? 1 : 0)});
            n = 1;
            while (anode == cur && n < 12) begin @(negedge clk); if (anode == cur) n++; end
            check("scan_dwell", n, RD);
        end

        // Leading-zero digit of 0x05
        run_op(8'h03, 8'h02, 1'b0, 1'b0, s, c, v);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("lz_seg", {25'd0, seg}, {25'd0, exp_seg(8'h05, (anode == 2'b01) ? 1 : 0)});
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
